sign_frame_sequencer: RTL and testbench
=======================================

Name: sign_frame_sequencer

Overview:
- Controller in front of the sign classifier.
- Accepts the binary object-image pixel stream (1 bit/pixel, raster order) and frames it into IMG_W x IMG_H images.
- Measures palm height (topmost to bottommost row containing an object pixel), launches the classifier with that height, and returns the 4-bit sign_value via valid/ack handshake.
- Owns timeout and no-object handling so downstream logic never stalls.

Parameters:
IMG_W, 64, pixels per row
IMG_H, 64, rows per frame
HW, 8, palm height width (saturating)
TIMEOUT, 255, max cycles in CLASSIFY awaiting cls_done (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
pix_in  in  1  object-image pixel (1 = object)
pix_valid  in  1  pixel beat valid
pix_sof  in  1  start-of-frame, qualifies first pixel of a frame
pix_ready  out  1  sequencer accepts pixel beat
cls_start  out  1  one-cycle classifier launch pulse
cls_palm_height  out  HW  measured height, stable through CLASSIFY
cls_done  in  1  classifier result valid
cls_sign  in  4  classifier result
sign_value  out  4  latched result
sign_valid  out  1  result available
sign_ack  in  1  consumer takes result
busy  out  1  state != IDLE
err_timeout  out  1  last frame timed out; cleared on next accepted sof

Behaviour:
- Accept: pix_valid && pix_ready.
- pix_ready = (state==IDLE || state==CAPTURE) && !rst. It is combinational.
- Reset (sync): state IDLE. cls_start, cls_palm_height, sign_value, sign_valid, busy, err_timeout all 0. Row/col counters, top/bottom/hit flags all cleared. Reset mid-frame or mid-CLASSIFY abandons everything; no cls_start is issued afterward.
- States: IDLE, CAPTURE, MEASURE, CLASSIFY, HOLD.
- IDLE:
  - Accepted beat with pix_sof=1 counts as pixel (row 0, col 0) and enters CAPTURE.
  - Accepted beat without sof is discarded.
- CAPTURE:
  - col counts 0..IMG_W-1, then wraps to 0 and increments row.
  - row_hit ORs pix_in across the row, including the current beat.
  - At each row end with row_hit=1: if no row hit yet, top=row; always bottom=row.
  - Accepted sof in CAPTURE restarts the frame: that beat becomes (0,0) and stats clear.
  - Accepting pixel (IMG_H-1, IMG_W-1) moves to MEASURE next cycle.
  - Idle pix_valid cycles do not advance counters.
- MEASURE (1 cycle):
  - height = bottom-top+1 if any row hit, else 0. Saturate to 2^HW-1.
  - Register into cls_palm_height.
  - height==0: sign_value=4'hE (no object), go to HOLD; classifier not started.
  - Otherwise go to CLASSIFY.
- CLASSIFY:
  - cls_start=1 in the first cycle only. cls_done is sampled from that cycle on.
  - On cls_done: sign_value=cls_sign, go to HOLD.
  - Cycle counter t=0.. in state. If t reaches TIMEOUT without cls_done: sign_value=4'hF, err_timeout=1, go to HOLD.
  - cls_done on the same cycle t==TIMEOUT wins; no error.
- HOLD:
  - sign_valid=1; sign_value stable until ack. pix_ready=0.
  - On sign_ack: IDLE next cycle, sign_valid=0.
  - sign_ack outside HOLD is ignored. cls_done outside CLASSIFY is ignored.
- Latency:
  - Last pixel accepted at cycle N: MEASURE at N+1; cls_start and valid height at N+2.
  - cls_done at cycle M: sign_valid=1 at M+1.
- sign_value keeps its last value after ack until overwritten.

Optional Feature:
- Macro SIGN_HEIGHT_OVERRIDE_EN.
- Defined:
  - Adds ports testing_switch (in 1) and palm_height_test (in HW).
  - If testing_switch=1 in MEASURE, cls_palm_height = palm_height_test, and the zero-height/no-object decision uses that value.
  - Pixel capture still runs for framing.
- Undefined: ports absent; measured height always used.

Test Plan:
- IMG_W=8, IMG_H=8, TIMEOUT=16. Frame with object pixels in rows 2..5; classifier returns 4'h7 two cycles after cls_start. Required: cls_palm_height=4 with cls_start at N+2; sign_value=7 and sign_valid=1; after ack, IDLE.
- All-zero frame. Required: no cls_start; sign_value=4'hE, sign_valid=1 at N+2; err_timeout=0.
- Classifier never asserts cls_done. Required: HOLD after 16 CLASSIFY cycles; sign_value=4'hF, err_timeout=1. Next accepted sof clears err_timeout.
- Pixels without sof in IDLE, then sof; sof reasserted at pixel 20 of a frame. Required: pre-sof beats ignored; frame restarts; height is computed only from the restarted frame. pix_valid gaps do not change the result.
- rst asserted mid-CAPTURE and mid-CLASSIFY. Required: all outputs 0 next cycle; no stray cls_start; next sof frame completes normally.
- With SIGN_HEIGHT_OVERRIDE_EN, testing_switch=1, palm_height_test=39, all-zero frame. Required: cls_palm_height=39, cls_start issued (no 4'hE).

Source files
------------

// File: rtl/sign_frame_sequencer.sv
// Frames a 1-bit object-image stream, measures palm height, launches the sign classifier
// and holds its result until acknowledged. Optional macro: SIGN_HEIGHT_OVERRIDE_EN.
module sign_frame_sequencer #(
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int HW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_in,
  input  logic          pix_valid,
  input  logic          pix_sof,
  output logic          pix_ready,
  output logic          cls_start,
  output logic [HW-1:0] cls_palm_height,
  input  logic          cls_done,
  input  logic [3:0]    cls_sign,
  output logic [3:0]    sign_value,
  output logic          sign_valid,
  input  logic          sign_ack,
  output logic          busy,
  output logic          err_timeout
`ifdef SIGN_HEIGHT_OVERRIDE_EN
  ,
  input  logic          testing_switch,
  input  logic [HW-1:0] palm_height_test
`endif
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [63:0] HMAX64 = (64'd1 << HW) - 64'd1;
  localparam logic [31:0] HMAX   = HMAX64[31:0];

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CAPTURE  = 3'd1;
  localparam logic [2:0] S_MEASURE  = 3'd2;
  localparam logic [2:0] S_CLASSIFY = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d, top_q, top_d, bot_q, bot_d;
  logic          row_hit_q, row_hit_d, any_q, any_d;
  logic [TW-1:0] t_q, t_d;
  logic [HW-1:0] hgt_q, hgt_d;
  logic [3:0]    sv_q, sv_d;
  logic          err_q, err_d;

  logic          acc, sof_acc, cap_beat, row_end, last_pix, hit, any_prev;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic [31:0]   meas_h;
  logic [HW-1:0] h_meas, h_sel;

  assign pix_ready       = ((state_q == S_IDLE) || (state_q == S_CAPTURE)) && !rst;
  assign busy            = (state_q != S_IDLE);
  assign sign_valid      = (state_q == S_HOLD);
  assign cls_start       = (state_q == S_CLASSIFY) && (t_q == '0);
  assign cls_palm_height = hgt_q;
  assign sign_value      = sv_q;
  assign err_timeout     = err_q;

  // An accepted sof always lands at (0,0) with fresh stats, in IDLE or mid-frame.
  assign acc      = pix_valid && pix_ready;
  assign sof_acc  = acc && pix_sof;
  assign cap_beat = acc && ((state_q == S_CAPTURE) || pix_sof);
  assign cur_col  = sof_acc ? '0 : col_q;
  assign cur_row  = sof_acc ? '0 : row_q;
  assign hit      = (!sof_acc && row_hit_q) || pix_in;
  assign any_prev = !sof_acc && any_q;
  assign row_end  = (cur_col == CW'(IMG_W - 1));
  assign last_pix = row_end && (cur_row == RW'(IMG_H - 1));

  assign meas_h = any_q ? (32'(bot_q) - 32'(top_q) + 32'd1) : 32'd0;
  assign h_meas = (meas_h > HMAX) ? HMAX[HW-1:0] : meas_h[HW-1:0];
`ifdef SIGN_HEIGHT_OVERRIDE_EN
  assign h_sel  = testing_switch ? palm_height_test : h_meas;
`else
  assign h_sel  = h_meas;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    top_d     = top_q;
    bot_d     = bot_q;
    row_hit_d = row_hit_q;
    any_d     = any_q;
    t_d       = t_q;
    hgt_d     = hgt_q;
    sv_d      = sv_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_CAPTURE: begin
        if (cap_beat) begin
          state_d = S_CAPTURE;
          if (sof_acc) err_d = 1'b0;
          any_d = any_prev;
          if (row_end) begin
            col_d     = '0;
            row_d     = last_pix ? '0 : cur_row + 1'b1;
            row_hit_d = 1'b0;
            if (hit) begin
              if (!any_prev) top_d = cur_row;
              bot_d = cur_row;
              any_d = 1'b1;
            end
            if (last_pix) state_d = S_MEASURE;
          end else begin
            col_d     = cur_col + 1'b1;
            row_d     = cur_row;
            row_hit_d = hit;
          end
        end
      end
      S_MEASURE: begin
        hgt_d = h_sel;
        t_d   = '0;
        if (h_sel == '0) begin
          sv_d    = 4'hE;
          state_d = S_HOLD;
        end else begin
          state_d = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        // A result arriving on the deadline cycle still counts as success.
        if (cls_done) begin
          sv_d    = cls_sign;
          state_d = S_HOLD;
        end else if (t_q == TW'(TIMEOUT)) begin
          sv_d    = 4'hF;
          err_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (sign_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      top_q     <= '0;
      bot_q     <= '0;
      row_hit_q <= 1'b0;
      any_q     <= 1'b0;
      t_q       <= '0;
      hgt_q     <= '0;
      sv_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      top_q     <= top_d;
      bot_q     <= bot_d;
      row_hit_q <= row_hit_d;
      any_q     <= any_d;
      t_q       <= t_d;
      hgt_q     <= hgt_d;
      sv_q      <= sv_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_sign_frame_sequencer.sv
// Randomized bench for sign_frame_sequencer against a frame-level reference model.
module tb_sign_frame_sequencer;
  localparam int W = 8, H = 8, HWD = 8, TMO = 16, NPIX = W * H;

  logic clk = 0, rst = 1, pix_in = 0, pix_valid = 0, pix_sof = 0;
  logic cls_done = 0, sign_ack = 0;
  logic [3:0] cls_sign = 0;
  logic pix_ready, cls_start, sign_valid, busy, err_timeout;
  logic [HWD-1:0] cls_palm_height;
  logic [3:0] sign_value;
  logic ovr_en = 0;
  logic [HWD-1:0] ovr_val = 0;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int start_cnt = 0, start_cyc = -1, start_h = 0, last_cyc = 0;

  sign_frame_sequencer #(.IMG_W(W), .IMG_H(H), .HW(HWD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready), .cls_start(cls_start), .cls_palm_height(cls_palm_height),
    .cls_done(cls_done), .cls_sign(cls_sign), .sign_value(sign_value),
    .sign_valid(sign_valid), .sign_ack(sign_ack), .busy(busy), .err_timeout(err_timeout)
`ifdef SIGN_HEIGHT_OVERRIDE_EN
    , .testing_switch(ovr_en), .palm_height_test(ovr_val)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cls_start) begin
      start_cnt++;
      start_cyc = cyc;
      start_h   = int'(cls_palm_height);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Height from the frame's row occupancy: first to last row with any object pixel.
  function automatic int model_h(input logic [NPIX-1:0] img);
    int top = -1, bot = -1, h;
    for (int r = 0; r < H; r++)
      if (|img[r*W +: W]) begin
        if (top < 0) top = r;
        bot = r;
      end
    if (top < 0) return 0;
    h = bot - top + 1;
    return (h > (2**HWD - 1)) ? (2**HWD - 1) : h;
  endfunction

  function automatic logic [NPIX-1:0] gen_img();
    logic [NPIX-1:0] img = '0;
    logic [W-1:0] rb;
    int top, bot;
    if ($urandom_range(0, 4) == 0) return img;
    top = $urandom_range(0, H-1);
    bot = $urandom_range(top, H-1);
    for (int r = top; r <= bot; r++) begin
      rb = W'($urandom);
      if (r == top || r == bot) rb[$urandom_range(0, W-1)] = 1'b1;
      img[r*W +: W] = rb;
    end
    return img;
  endfunction

  // One cycle of pixel-side stimulus with ignored-noise on cls_done / sign_ack.
  task automatic drive(input logic v, input logic p, input logic s);
    pix_valid = v; pix_in = p; pix_sof = s;
    cls_done  = 1'($urandom_range(0, 1));
    cls_sign  = 4'($urandom);
    sign_ack  = 1'($urandom_range(0, 1));
    last_cyc  = cyc;
    @(posedge clk); #1;
    pix_valid = 0; pix_sof = 0; cls_done = 0; sign_ack = 0;
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_img(input logic [NPIX-1:0] img, input int restart_at);
    repeat ($urandom_range(0, 2)) drive(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < restart_at; i++) begin
      gap();
      drive(1'b1, 1'($urandom_range(0, 1)), i == 0);
    end
    for (int i = 0; i < NPIX; i++) begin
      gap();
      drive(1'b1, img[i], i == 0);
      if (i == 0) begin
        chk("sof_err_clr", err_timeout, 0);
        chk("sof_busy", busy, 1);
      end
    end
  endtask

  task automatic finish_img(input int hexp, input int dly, input logic [3:0] sgn);
    int n = last_cyc, k = 0, s0 = start_cnt, vc;
    bit tmo;
    logic [3:0] vexp;
    tmo  = (hexp != 0) && (dly < 0 || dly > TMO);
    vexp = (hexp == 0) ? 4'hE : (tmo ? 4'hF : sgn);
    while (!sign_valid && k < 80) begin
      if (cyc == n + 1) begin
        cls_done = 1'b1; cls_sign = ~sgn;
      end else begin
        cls_done = (hexp != 0) && (dly >= 0) && (cyc == n + 2 + dly);
        cls_sign = cls_done ? sgn : 4'($urandom);
      end
      @(posedge clk); #1;
      cls_done = 0;
      k++;
    end
    vc = cyc;
    chk("hold_reached", k < 80, 1);
    chk("valid_cyc", vc, (hexp == 0) ? n + 2 : (tmo ? n + 3 + TMO : n + 3 + dly));
    chk("sign_value", sign_value, vexp);
    chk("err_timeout", err_timeout, tmo);
    chk("palm_h_reg", cls_palm_height, hexp);
    chk("ready_hold", pix_ready, 0);
    repeat ($urandom_range(0, 3)) begin
      pix_valid = 1; pix_sof = 1; cls_done = 1; cls_sign = ~vexp;
      @(posedge clk); #1;
      pix_valid = 0; pix_sof = 0; cls_done = 0;
      chk("hold_stable", {sign_valid, busy, sign_value}, {1'b1, 1'b1, vexp});
    end
    sign_ack = 1;
    @(posedge clk); #1;
    sign_ack = 0;
    chk("ack_valid", sign_valid, 0);
    chk("ack_busy", busy, 0);
    chk("ack_keep", sign_value, vexp);
    chk("ack_ready", pix_ready, 1);
    chk("ack_err", err_timeout, tmo);
    chk("start_cnt", start_cnt - s0, hexp != 0);
    if (hexp != 0) begin
      chk("start_cyc", start_cyc, n + 2);
      chk("start_h", start_h, hexp);
    end
  endtask

  task automatic run(input logic [NPIX-1:0] img, input int restart_at, input int dly, input logic [3:0] sgn);
    send_img(img, restart_at);
    finish_img(ovr_en ? int'(ovr_val) : model_h(img), dly, sgn);
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    chk("rst_ready", pix_ready, 0);
    chk("rst_outs", {cls_start, cls_palm_height, sign_value, sign_valid, busy, err_timeout}, 0);
    rst = 0;
    #1;
    chk("rst_ready_rel", pix_ready, 1);
  endtask

  logic [NPIX-1:0] img;
  int s0, dly, sel;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    img = '0;
    img[2*W + 3] = 1'b1; img[3*W + 0] = 1'b1; img[5*W + 7] = 1'b1;
    run(img, -1, 2, 4'h7);
    run('0, -1, 2, 4'h7);
    run(img, -1, -1, 4'h3);
    run(img, -1, TMO, 4'h9);
    img = '0;
    img[4*W + 1] = 1'b1; img[6*W + 6] = 1'b1;
    run(img, 20, 5, 4'h2);

    // reset while capturing
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, i == 0);
    do_reset();
    repeat (10) drive(1'b1, 1'b1, 1'b0);
    chk("rst_cap_nostart", start_cnt - s0, 0);
    chk("rst_cap_idle", busy, 0);
    run(gen_img(), -1, 1, 4'hA);

    // reset while classifying
    img = '0;
    img[1*W + 2] = 1'b1; img[6*W + 2] = 1'b1;
    s0 = start_cnt;
    send_img(img, -1);
    repeat (4) @(posedge clk);
    #1;
    chk("cls_started", start_cnt - s0, 1);
    do_reset();
    repeat (30) @(posedge clk);
    #1;
    chk("rst_cls_nostart", start_cnt - s0, 1);
    chk("rst_cls_idle", {busy, sign_valid}, 0);
    run(img, -1, 3, 4'h6);

    for (int f = 0; f < 20; f++) begin
      sel = $urandom_range(0, 5);
      dly = (sel == 0) ? -1 : (sel == 1) ? TMO : $urandom_range(0, TMO - 1);
      run(gen_img(), ($urandom_range(0, 3) == 0) ? $urandom_range(1, NPIX - 2) : -1, dly, 4'($urandom));
    end

`ifdef SIGN_HEIGHT_OVERRIDE_EN
    ovr_en = 1; ovr_val = 8'd39;
    run('0, -1, 3, 4'h5);
    ovr_en = 0;
    run('0, -1, 3, 4'h5);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
